// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : Small FIFO between fetch and the sign extender. Each entry
//               holds its immediate-decode result, which is computed at push.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] Instruction,
    input  logic [63:0] PCIn,
    input  logic        Flush,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [25:0] Imm26,
    output logic [2:0]  ExtCtrl,
    output logic        ImmUsed,
    output logic [10:0] Opcode,
    output logic [63:0] PCOut
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = 64 + 11 + 26 + 1 + 3;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];

    logic                 w_push;
    logic                 w_pop;
    logic [2:0]           w_ext;
    logic                 w_used;
    logic [c_ENTRY_W-1:0] w_entry_in;
    logic [c_ENTRY_W-1:0] w_head;

    // Decode rules are checked in priority order; the first match wins.
    always_comb begin
        w_ext  = 3'b000;
        w_used = 1'b0;
        if (Instruction[31:22] inside {10'b1001000100, 10'b1011000100,
                                       10'b1101000100, 10'b1111000100,
                                       10'b1001001000, 10'b1011001000,
                                       10'b1101001000}) begin
            w_ext  = 3'b000;
            w_used = 1'b1;
        end else if (Instruction[31:21] inside {11'b11111000010, 11'b11111000000}) begin
            w_ext  = 3'b001;
            w_used = 1'b1;
        end else if (Instruction[31:26] == 6'b000101) begin
            w_ext  = 3'b010;
            w_used = 1'b1;
        end else if (Instruction[31:24] inside {8'b10110100, 8'b10110101}) begin
            w_ext  = 3'b011;
            w_used = 1'b1;
        end else if (Instruction[31:23] == 9'b110100101) begin
            w_ext  = {1'b1, Instruction[22:21]};
            w_used = 1'b1;
        end
    end

    assign InReady  = (r_count < c_DEPTH);
    assign OutValid = (r_count != '0);

    // Flush wins over any handshake in the same cycle.
    assign w_push = InValid & InReady & ~Flush;
    assign w_pop  = OutValid & OutReady & ~Flush;

    assign w_entry_in = {PCIn, Instruction[31:21], Instruction[25:0], w_used, w_ext};

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only visible while OutValid is high.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry_in;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign {PCOut, Opcode, Imm26, ImmUsed, ExtCtrl} = OutValid ? w_head : '0;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// Bench for imm_decode_stage: directed scenarios followed by a long random
// push/pop/flush run compared against a queue-based reference model.
module tb_imm_decode_stage;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] Instruction = '0;
    logic [63:0] PCIn = '0;
    logic        Flush = 1'b0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [25:0] Imm26;
    logic [2:0]  ExtCtrl;
    logic        ImmUsed;
    logic [10:0] Opcode;
    logic [63:0] PCOut;

    int checks = 0;
    int errors = 0;

    logic [95:0] model_q [$];

    imm_decode_stage #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Instruction(Instruction), .PCIn(PCIn), .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady), .Imm26(Imm26),
        .ExtCtrl(ExtCtrl), .ImmUsed(ImmUsed), .Opcode(Opcode), .PCOut(PCOut)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Returns {ImmUsed, ExtCtrl} from the instruction-class tables.
    function automatic logic [3:0] ref_decode(input logic [31:0] ins);
        logic [31:0] top10 = ins >> 22;
        logic [31:0] top11 = ins >> 21;
        logic [31:0] top6  = ins >> 26;
        logic [31:0] top8  = ins >> 24;
        logic [31:0] top9  = ins >> 23;
        logic [31:0] hw    = (ins >> 21) & 32'd3;
        if (top10 inside {32'h244, 32'h2C4, 32'h344, 32'h3C4, 32'h248, 32'h2C8, 32'h348})
            return 4'b1000;
        if (top11 inside {32'h7C2, 32'h7C0})
            return 4'b1001;
        if (top6 == 32'd5)
            return 4'b1010;
        if (top8 inside {32'hB4, 32'hB5})
            return 4'b1011;
        if (top9 == 32'h1A5)
            return 4'b1100 | hw[3:0];
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        logic [95:0] head;
        logic [3:0]  dec;
        logic        vld;
        vld  = (model_q.size() != 0);
        head = vld ? model_q[0] : 96'd0;
        dec  = vld ? ref_decode(head[95:64]) : 4'd0;
        chk("OutValid", OutValid, vld);
        chk("InReady", InReady, model_q.size() < DEPTH);
        chk("Imm26", Imm26, vld ? head[89:64] : 64'd0);
        chk("Opcode", Opcode, vld ? head[95:85] : 64'd0);
        chk("PCOut", PCOut, head[63:0]);
        chk("ExtCtrl", ExtCtrl, dec[2:0]);
        chk("ImmUsed", ImmUsed, dec[3]);
    endtask

    // One clock cycle: drive, check mid-cycle, then advance model at the edge.
    task automatic cycle(input logic inv, input logic [31:0] ins, input logic [63:0] pc,
                         input logic outr, input logic fl);
        logic accept;
        InValid = inv; Instruction = ins; PCIn = pc; OutReady = outr; Flush = fl;
        @(negedge CLK);
        compare_model();
        @(posedge CLK);
        if (fl) begin
            model_q.delete();
        end else begin
            accept = inv && (model_q.size() < DEPTH);
            if (outr && model_q.size() != 0) void'(model_q.pop_front());
            if (accept) model_q.push_back({ins, pc});
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [9:0]  alu [7] = '{10'h244, 10'h2C4, 10'h344, 10'h3C4, 10'h248, 10'h2C8, 10'h348};
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 5))
            0: return {alu[$urandom_range(0, 6)], r[21:0]};
            1: return {($urandom_range(0, 1) != 0) ? 11'h7C2 : 11'h7C0, r[20:0]};
            2: return {6'b000101, r[25:0]};
            3: return {7'b1011010, r[24:0]};
            4: return {9'b110100101, r[22:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        // Reset state, observed without any clock edge having occurred.
        #2;
        chk("rst_OutValid", OutValid, 1'b0);
        chk("rst_Imm26", Imm26, 26'd0);
        chk("rst_PCOut", PCOut, 64'd0);
        #10;
        Reset = 1'b0;
        #1;
        chk("rst_InReady", InReady, 1'b1);
        @(posedge CLK);
        #1;

        // ADDI into empty buffer.
        cycle(1'b1, 32'h91000421, 64'h40, 1'b0, 1'b0);
        chk("addi_OutValid", OutValid, 1'b1);
        chk("addi_ExtCtrl", ExtCtrl, 3'b000);
        chk("addi_ImmUsed", ImmUsed, 1'b1);
        chk("addi_Imm26", Imm26, 26'h1000421);
        chk("addi_PCOut", PCOut, 64'h40);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Move-wide then B, fill with no pops, then drain.
        cycle(1'b1, 32'hD2A00020, 64'h100, 1'b0, 1'b0);
        cycle(1'b1, 32'h14000003, 64'h104, 1'b0, 1'b0);
        chk("full_InReady", InReady, 1'b0);
        chk("movw_ExtCtrl", ExtCtrl, 3'b101);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("afterpop_InReady", InReady, 1'b1);
        chk("b_ExtCtrl", ExtCtrl, 3'b010);
        chk("b_PCOut", PCOut, 64'h104);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Load then R-type while popping every cycle.
        cycle(1'b1, 32'hF8408041, 64'h200, 1'b1, 1'b0);
        chk("ld_ExtCtrl", ExtCtrl, 3'b001);
        chk("ld_ImmUsed", ImmUsed, 1'b1);
        cycle(1'b1, 32'h8B020020, 64'h204, 1'b1, 1'b0);
        chk("r_OutValid", OutValid, 1'b1);
        chk("r_ExtCtrl", ExtCtrl, 3'b000);
        chk("r_ImmUsed", ImmUsed, 1'b0);
        chk("r_PCOut", PCOut, 64'h204);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Flush with a simultaneous push drops everything.
        cycle(1'b1, 32'h91000421, 64'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h14000003, 64'h304, 1'b0, 1'b0);
        cycle(1'b1, 32'hB4000040, 64'h308, 1'b1, 1'b1);
        chk("flush_OutValid", OutValid, 1'b0);
        chk("flush_InReady", InReady, 1'b1);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with one entry buffered.
        cycle(1'b1, 32'h91000421, 64'h400, 1'b0, 1'b0);
        InValid = 1'b0; OutReady = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_OutValid", OutValid, 1'b0);
        chk("arst_Imm26", Imm26, 26'd0);
        chk("arst_PCOut", PCOut, 64'd0);
        model_q.delete();
        #1;
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        cycle(1'b1, 32'hB4000040, 64'h500, 1'b0, 1'b0);
        chk("cbz_OutValid", OutValid, 1'b1);
        chk("cbz_ExtCtrl", ExtCtrl, 3'b011);
        chk("cbz_ImmUsed", ImmUsed, 1'b1);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Random push/pop/flush traffic.
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 99) < 60, rand_instr(), {$urandom, $urandom},
                  $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
